adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter NREQ, fixed at 3, number of requesters: 0 = PC+4, 1 = branch target, 2 = load/store address.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester grant/accept; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  operand B, same packing as req_a.
REQ-009 rsp_valid  output  1  result register holds a valid sum.
REQ-010 rsp_ready  input  1  downstream consumes the result when high together with rsp_valid.
REQ-011 rsp_sum  output  WIDTH  registered sum, (a+b) mod 2^WIDTH.
REQ-012 rsp_id  output  2  index of the requester that owns rsp_sum.
REQ-013 grant_cnt  output  16  count of accepted requests, wraps 0xFFFF -> 0x0000.

Function
REQ-014 The block SHALL instantiate one adder module of width WIDTH as its only arithmetic resource.
REQ-015 Adder operands SHALL be muxed from the granted requester's req_a/req_b in the same cycle as the grant.
REQ-016 The block SHALL hold a one-entry output register (rsp_valid, rsp_sum, rsp_id).
REQ-017 can_accept = !rsp_valid || rsp_ready; no grant is issued while can_accept is low.
REQ-018 When can_accept is high and any req_valid is set, exactly one req_ready bit SHALL be set, chosen round-robin.
REQ-019 Round-robin: search starts at index ptr, then ptr+1, ptr+2 (mod 3); first valid requester wins.
REQ-020 On a grant to requester g, ptr SHALL become (g+1) mod 3 on the next edge; otherwise ptr holds.
REQ-021 req_ready SHALL be combinational from req_valid, ptr and can_accept; it SHALL never be high for a requester whose req_valid is low.
REQ-022 Latency: a grant in cycle N loads the sum and id in cycle N+1 and sets rsp_valid.
REQ-023 Consume and grant in the same cycle SHALL give back-to-back throughput of one result per cycle.
REQ-024 Consume with no grant SHALL clear rsp_valid on the next edge.
REQ-025 With rsp_valid high and rsp_ready low, rsp_sum, rsp_id and rsp_valid SHALL hold unchanged, and all req_ready SHALL be low.
REQ-026 Carry-out SHALL be discarded; overflow wraps modulo 2^WIDTH.
REQ-027 grant_cnt SHALL increment by 1 on every edge where any req_ready && req_valid is high.
REQ-028 Requesters hold req_valid and operands stable until accepted; the block does not capture unaccepted requests.

Reset
REQ-029 Asserting reset SHALL immediately clear rsp_valid, rsp_sum, rsp_id, grant_cnt and ptr to 0, regardless of clk.
REQ-030 While reset is high, req_ready SHALL be all zeros.
REQ-031 Reset asserted with a held result SHALL discard it; no result is produced after deassertion without a new grant.
REQ-032 After deassertion, the first grant SHALL use ptr = 0, so requester 0 has priority.

Verification
REQ-033 Single request: after reset, req_valid=3'b010, a=0x1000, b=0x0000_0040 -> req_ready=3'b010 same cycle; next cycle rsp_valid=1, rsp_sum=0x0000_1040, rsp_id=1, grant_cnt=1.
REQ-034 Round-robin: all three valid every cycle, rsp_ready=1 -> grants 0,1,2,0,1,2 on consecutive cycles, with one result per cycle.
REQ-035 Backpressure: result pending with rsp_ready=0 for 5 cycles while req_valid=3'b111 -> req_ready=0 throughout, rsp_sum/rsp_id stable, grant_cnt unchanged.
REQ-036 Wrap: a=0xFFFF_FFFF, b=0x0000_0002 -> rsp_sum=0x0000_0001.
REQ-037 Mid-operation reset: assert reset between clock edges while rsp_valid=1 -> rsp_valid=0 immediately; after release with req_valid=3'b111 the first grant is to requester 0.
REQ-038 Counter wrap: force 65536 grants -> grant_cnt returns to 0x0000.

Source files
------------

// File: rtl/adder_arbiter.sv
// Shared-adder front end: three requesters compete round-robin for one WIDTH-bit
// adder whose result lands in a one-entry valid/ready output register.

module adder_arbiter_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);
    // Carry-out is dropped on purpose: results wrap modulo 2^WIDTH.
    assign sum_o = a_i + b_i;
endmodule

module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic [1:0]            rsp_id,
    output logic [15:0]           grant_cnt
);
    // Handshakes: a request transfers on an edge where req_valid[i] && req_ready[i];
    // a result transfers on an edge where rsp_valid && rsp_ready.

    logic [1:0]       ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [1:0]       rsp_id_q, rsp_id_d;
    logic [15:0]      grant_cnt_q, grant_cnt_d;

    logic             can_accept;
    logic             grant_any;
    logic [1:0]       grant_idx;
    logic [1:0]       cand [3];
    logic [WIDTH-1:0] op_a, op_b, add_sum;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign can_accept = !rsp_valid_q || rsp_ready;

    always_comb begin
        cand[0] = ptr_q;
        cand[1] = inc3(ptr_q);
        cand[2] = inc3(inc3(ptr_q));
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!grant_any && req_valid[cand[k]]) begin
                grant_any = 1'b1;
                grant_idx = cand[k];
            end
        end
        // Reset is folded in here so req_ready is quiet for the whole reset pulse.
        if (reset || !can_accept) begin
            grant_any = 1'b0;
        end
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign op_a = req_a[grant_idx*WIDTH +: WIDTH];
    assign op_b = req_b[grant_idx*WIDTH +: WIDTH];

    adder_arbiter_add #(.WIDTH(WIDTH)) u_add (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (add_sum)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        grant_cnt_d = grant_cnt_q;
        if (grant_any) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_id_d    = grant_idx;
            ptr_d       = inc3(grant_idx);
            grant_cnt_d = grant_cnt_q + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= 2'd0;
            grant_cnt_q <= 16'd0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic, checked by a
// round-robin reference model feeding an expected-result queue.

module tb_adder_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [3*W-1:0] req_a, req_b;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_sum;
    logic [1:0]    rsp_id;
    logic [15:0]   grant_cnt;

    logic [2:0]    pend = 3'b000;
    logic [W-1:0]  opa [3];
    logic [W-1:0]  opb [3];
    logic [2:0]    accepted = 3'b000;

    // reference model state
    logic          m_valid = 1'b0;
    int            m_ptr = 0;
    logic [15:0]   m_cnt = 16'd0;
    logic [W+1:0]  exp_q [$];

    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_sum;
    logic [1:0]    prev_id;

    int            n_chk = 0;
    int            n_pass = 0;

    assign req_valid = pend;
    assign req_a = {opa[2], opa[1], opa[0]};
    assign req_b = {opb[2], opb[1], opb[0]};

    adder_arbiter #(.WIDTH(W), .NREQ(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: round-robin pick from the current pointer, one-entry output register.
    always @(negedge clk) begin
        int g;
        logic [2:0] exp_ready;
        if (reset) begin
            chk("ready_in_reset", {61'd0, req_ready}, 64'd0);
            accepted = 3'b000;
        end else begin
            g = -1;
            if (!m_valid || rsp_ready) begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (m_ptr + k) % 3;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
            chk("req_ready", {61'd0, req_ready}, {61'd0, exp_ready});
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_valid});
            chk("grant_cnt", {48'd0, grant_cnt}, {48'd0, m_cnt});
            accepted = req_ready & req_valid;
            if (g >= 0) begin
                logic [W-1:0] s;
                logic [1:0]   gi;
                s  = opa[g] + opb[g];
                gi = 2'(g);
                exp_q.push_back({gi, s});
                m_ptr   = (g + 1) % 3;
                m_valid = 1'b1;
                m_cnt   = m_cnt + 16'd1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: pops on every consumed result and checks that held results stay put.
    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
                chk("hold_sum", {32'd0, rsp_sum}, {32'd0, prev_sum});
                chk("hold_id", {62'd0, rsp_id}, {62'd0, prev_id});
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_sum  = rsp_sum;
            prev_id   = rsp_id;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {30'd0, rsp_id, rsp_sum}, 64'hDEAD);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    chk("result", {30'd0, rsp_id, rsp_sum}, {30'd0, e});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        pend = pend & ~accepted;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_cnt   = 16'd0;
        exp_q.delete();
    endtask

    // Reset asserted between edges, released between later edges.
    task automatic pulse_reset(input logic [2:0] pend_after);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_valid_now", {63'd0, rsp_valid}, 64'd0);
        chk("rst_sum_now", {32'd0, rsp_sum}, 64'd0);
        chk("rst_cnt_now", {48'd0, grant_cnt}, 64'd0);
        @(posedge clk);
        #2;
        pend = pend_after;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            opa[i] = 32'd0;
            opb[i] = 32'd0;
        end
        // Reset state, with requests waving to confirm req_ready stays low
        pend = 3'b111;
        #2;
        chk("init_ready", {61'd0, req_ready}, 64'd0);
        chk("init_valid", {63'd0, rsp_valid}, 64'd0);
        chk("init_sum", {32'd0, rsp_sum}, 64'd0);
        chk("init_id", {62'd0, rsp_id}, 64'd0);
        chk("init_cnt", {48'd0, grant_cnt}, 64'd0);
        @(posedge clk);
        #2;
        pend = 3'b000;
        reset = 1'b0;
        step();

        // Single request from requester 1
        opa[1] = 32'h0000_1000;
        opb[1] = 32'h0000_0040;
        pend = 3'b010;
        #1;
        chk("single_ready", {61'd0, req_ready}, 64'h2);
        step();
        chk("single_valid", {63'd0, rsp_valid}, 64'd1);
        chk("single_sum", {32'd0, rsp_sum}, 64'h1040);
        chk("single_id", {62'd0, rsp_id}, 64'd1);
        chk("single_cnt", {48'd0, grant_cnt}, 64'd1);

        // Backpressure: result held, all requesters waiting
        for (int i = 0; i < 3; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        pend = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", {61'd0, req_ready}, 64'd0);
            step();
            chk("bp_sum", {32'd0, rsp_sum}, 64'h1040);
            chk("bp_id", {62'd0, rsp_id}, 64'd1);
            chk("bp_cnt", {48'd0, grant_cnt}, 64'd1);
        end

        // Reset while holding a result, then round-robin from requester 0
        rsp_ready = 1'b1;
        pulse_reset(3'b111);
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", {61'd0, req_ready}, {61'd0, 3'b001 << (k % 3)});
            step();
            pend = 3'b111;
            chk("rr_valid", {63'd0, rsp_valid}, 64'd1);
            chk("rr_id", {62'd0, rsp_id}, 64'(k % 3));
        end

        // Wraparound sum
        pend = 3'b001;
        opa[0] = 32'hFFFF_FFFF;
        opb[0] = 32'h0000_0002;
        #1;
        chk("wrap_ready", {61'd0, req_ready}, 64'h1);
        step();
        chk("wrap_sum", {32'd0, rsp_sum}, 64'h1);
        chk("wrap_id", {62'd0, rsp_id}, 64'd0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 60) begin
                    opa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    opb[i] = $urandom;
                    pend[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        pend = 3'b000;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("drained", 64'(exp_q.size()), 64'd0);

        // Counter wrap over 65536 back-to-back grants
        pulse_reset(3'b111);
        for (int c = 0; c < 65536; c++) begin
            step();
            pend = 3'b111;
        end
        chk("cnt_wrap", {48'd0, grant_cnt}, 64'd0);
        pend = 3'b000;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
